// File: rtl/instr_seq.sv
// ---------------------------------------------------------------------------
// instr_seq -- fetch/execute sequencer and instruction decoder, 8-bit CPU.
//
// The instruction byte is latched from the RAM data bus during FETCH and
// decoded in the following EXEC cycle into one-hot strobes for the
// control-signal generator. Single-step (WAIT), halt/resume (HALT) and a
// retired-instruction counter are layered on top of the basic
// two-cycle fetch/execute loop.
//
// Ports
//   clk        rising-edge clock
//   rst        asynchronous active-high reset
//   ram_dout   RAM data bus, instruction byte while in FETCH
//   step_mode  1 = park in WAIT after every instruction
//   step       one-cycle pulse, leaves WAIT
//   resume     one-cycle pulse, leaves HALT
//   ir         instruction register
//   sm         phase bit, 0 fetch / 1 execute, wait or halt
//   state      00 FETCH, 01 EXEC, 10 WAIT, 11 HALT
//   mova..halt one-hot instruction strobes
//   instr_cnt  retired-instruction count, wraps mod 2^CNT_W
// ---------------------------------------------------------------------------
module instr_seq #(
  parameter int          CNT_W    = 16,
  parameter logic [7:0]  RESET_IR = 8'h00
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [7:0]       ram_dout,
  input  logic             step_mode,
  input  logic             step,
  input  logic             resume,
  output logic [7:0]       ir,
  output logic             sm,
  output logic [1:0]       state,
  output logic             mova,
  output logic             movb,
  output logic             movc,
  output logic             add,
  output logic             sub,
  output logic             and1,
  output logic             not1,
  output logic             rsr,
  output logic             rsl,
  output logic             jmp,
  output logic             jz,
  output logic             jc,
  output logic             in1,
  output logic             out1,
  output logic             nop,
  output logic             halt,
  output logic [CNT_W-1:0] instr_cnt
);

  typedef enum logic [1:0] {
    S_FETCH = 2'b00,
    S_EXEC  = 2'b01,
    S_WAIT  = 2'b10,
    S_HALT  = 2'b11
  } state_e;

  typedef struct packed {
    logic mova, movb, movc, add, sub, and1, not1, rsr;
    logic rsl, jmp, jz, jc, in1, out1, nop, halt;
  } strb_t;

  state_e           state_q;
  logic [7:0]       ir_q;
  logic             sm_q;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;
  logic             halt_op;
  strb_t            dec;

  assign halt_op = (ir_q[7:4] == 4'b0001);
  assign cnt_d   = cnt_q + 1'b1;

  // Sequencer. step/resume only matter in WAIT/HALT; elsewhere they fall
  // through unused, so stray pulses are dropped rather than remembered.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_FETCH;
      ir_q    <= RESET_IR;
      sm_q    <= 1'b0;
      cnt_q   <= '0;
    end else begin
      case (state_q)
        S_FETCH: begin
          ir_q    <= ram_dout;
          state_q <= S_EXEC;
          sm_q    <= 1'b1;
        end
        S_EXEC: begin
          cnt_q <= cnt_d;
          if (halt_op) begin
            state_q <= S_HALT;
            sm_q    <= 1'b1;
          end else if (step_mode) begin
            state_q <= S_WAIT;
            sm_q    <= 1'b1;
          end else begin
            state_q <= S_FETCH;
            sm_q    <= 1'b0;
          end
        end
        S_WAIT: begin
          if (step || !step_mode) begin
            state_q <= S_FETCH;
            sm_q    <= 1'b0;
          end
        end
        S_HALT: begin
          if (resume) begin
            state_q <= S_FETCH;
            sm_q    <= 1'b0;
          end
        end
        default: begin
          state_q <= S_FETCH;
          sm_q    <= 1'b0;
        end
      endcase
    end
  end

  // Decode: strobes are live only in EXEC; HALT keeps just the halt strobe.
  // Every opcode in EXEC lands on exactly one strobe (unused encodings -> nop).
  always_comb begin
    dec = '0;
    if (state_q == S_EXEC) begin
      case (ir_q[7:4])
        4'b0000: dec.nop  = 1'b1;
        4'b0001: dec.halt = 1'b1;
        4'b0010: dec.in1  = 1'b1;
        4'b0011: dec.out1 = 1'b1;
        4'b0101: dec.not1 = 1'b1;
        4'b0110: dec.sub  = 1'b1;
        4'b1001: dec.add  = 1'b1;
        4'b1011: dec.and1 = 1'b1;
        4'b0100: begin
          // movb has priority: 4F is a movb, not a movc
          if (ir_q[3:2] == 2'b11)      dec.movb = 1'b1;
          else if (ir_q[1:0] == 2'b11) dec.movc = 1'b1;
          else                         dec.mova = 1'b1;
        end
        4'b0111: begin
          case (ir_q[3:2])
            2'b00:   dec.jmp = 1'b1;
            2'b01:   dec.jz  = 1'b1;
            2'b10:   dec.jc  = 1'b1;
            default: dec.nop = 1'b1;
          endcase
        end
        4'b1010: begin
          case (ir_q[3:2])
            2'b00:   dec.rsr = 1'b1;
            2'b01:   dec.rsl = 1'b1;
            default: dec.nop = 1'b1;
          endcase
        end
        default: dec.nop = 1'b1;
      endcase
    end else if (state_q == S_HALT) begin
      dec.halt = 1'b1;
    end
  end

  assign ir        = ir_q;
  assign sm        = sm_q;
  assign state     = state_q;
  assign instr_cnt = cnt_q;

  assign mova = dec.mova;
  assign movb = dec.movb;
  assign movc = dec.movc;
  assign add  = dec.add;
  assign sub  = dec.sub;
  assign and1 = dec.and1;
  assign not1 = dec.not1;
  assign rsr  = dec.rsr;
  assign rsl  = dec.rsl;
  assign jmp  = dec.jmp;
  assign jz   = dec.jz;
  assign jc   = dec.jc;
  assign in1  = dec.in1;
  assign out1 = dec.out1;
  assign nop  = dec.nop;
  assign halt = dec.halt;

endmodule

// File: tb/tb_instr_seq.sv
// ---------------------------------------------------------------------------
// tb_instr_seq -- self-checking bench for instr_seq (CNT_W=4 so the counter
// wrap is reachable quickly). Expected strobe vectors are queued when a byte
// is presented in FETCH and popped when the DUT reaches EXEC.
// Strobe vector bit order: {mova,movb,movc,add,sub,and1,not1,rsr,
//                           rsl,jmp,jz,jc,in1,out1,nop,halt}
// ---------------------------------------------------------------------------
module tb_instr_seq;
  localparam int CW = 4;

  localparam int B_HALT = 0,  B_NOP = 1,  B_OUT1 = 2,  B_IN1 = 3;
  localparam int B_JC   = 4,  B_JZ  = 5,  B_JMP  = 6,  B_RSL = 7;
  localparam int B_RSR  = 8,  B_NOT1 = 9, B_AND1 = 10, B_SUB = 11;
  localparam int B_ADD  = 12, B_MOVC = 13, B_MOVB = 14, B_MOVA = 15;

  logic          clk = 1'b0;
  logic          rst;
  logic [7:0]    ram_dout;
  logic          step_mode, step, resume;
  logic [7:0]    ir;
  logic          sm;
  logic [1:0]    state;
  logic          mova, movb, movc, add, sub, and1, not1, rsr;
  logic          rsl, jmp, jz, jc, in1, out1, nop, halt;
  logic [CW-1:0] instr_cnt;

  int errs   = 0;
  int checks = 0;
  int exp_cnt = 0;
  logic [15:0] sb_q[$];

  instr_seq #(.CNT_W(CW), .RESET_IR(8'h00)) dut (
    .clk(clk), .rst(rst), .ram_dout(ram_dout), .step_mode(step_mode),
    .step(step), .resume(resume), .ir(ir), .sm(sm), .state(state),
    .mova(mova), .movb(movb), .movc(movc), .add(add), .sub(sub),
    .and1(and1), .not1(not1), .rsr(rsr), .rsl(rsl), .jmp(jmp), .jz(jz),
    .jc(jc), .in1(in1), .out1(out1), .nop(nop), .halt(halt),
    .instr_cnt(instr_cnt)
  );

  always #5 clk = ~clk;

  function automatic logic [15:0] strb();
    return {mova, movb, movc, add, sub, and1, not1, rsr,
            rsl, jmp, jz, jc, in1, out1, nop, halt};
  endfunction

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  // Inputs change and outputs are sampled 1 time unit after the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present one byte in FETCH and check its EXEC cycle; leaves the bench in
  // the cycle after EXEC.
  task automatic exec_one(input logic [7:0] b, input int bit_idx);
    logic [15:0] e;
    for (int i = 0; i < 30 && state != 2'b00; i++) tick();
    chk("fetch_reached", {30'd0, state}, 32'd0);
    chk("fetch_sm", {31'd0, sm}, 32'd0);
    chk("fetch_strobes", {16'd0, strb()}, 32'd0);
    ram_dout = b;
    sb_q.push_back(16'h1 << bit_idx);
    tick();
    ram_dout = 8'hxx;
    chk("exec_state", {30'd0, state}, 32'd1);
    chk("exec_sm", {31'd0, sm}, 32'd1);
    chk("exec_ir", {24'd0, ir}, {24'd0, b});
    chk("exec_onehot", {31'd0, $onehot(strb())}, 32'd1);
    if (sb_q.size() == 0) chk("sb_empty", 32'd1, 32'd0);
    else begin
      e = sb_q.pop_front();
      chk($sformatf("decode_%02h", b), {16'd0, strb()}, {16'd0, e});
    end
    tick();
    exp_cnt = (exp_cnt + 1) % (1 << CW);
    chk("cnt", {28'd0, instr_cnt}, exp_cnt);
  endtask

  typedef struct { logic [7:0] b; int idx; } vec_t;
  vec_t tbl[$];

  initial begin
    rst = 1'b1; ram_dout = 8'h00; step_mode = 1'b0; step = 1'b0; resume = 1'b0;
    tick(); tick();
    chk("rst_state", {30'd0, state}, 32'd0);
    chk("rst_sm", {31'd0, sm}, 32'd0);
    chk("rst_ir", {24'd0, ir}, 32'd0);
    chk("rst_cnt", {28'd0, instr_cnt}, 32'd0);
    chk("rst_strobes", {16'd0, strb()}, 32'd0);
    rst = 1'b0;

    // basic add, then decode table
    exec_one(8'h96, B_ADD);
    chk("after_add_state", {30'd0, state}, 32'd0);
    tbl = '{'{8'h4C, B_MOVB}, '{8'h43, B_MOVC}, '{8'h41, B_MOVA}, '{8'h4F, B_MOVB},
            '{8'h74, B_JZ},   '{8'h7C, B_NOP},  '{8'hA4, B_RSL},  '{8'hA8, B_NOP},
            '{8'hF0, B_NOP},  '{8'h00, B_NOP},  '{8'h20, B_IN1},  '{8'h30, B_OUT1},
            '{8'h50, B_NOT1}, '{8'h60, B_SUB},  '{8'hBF, B_AND1}, '{8'h70, B_JMP},
            '{8'h78, B_JC},   '{8'hA0, B_RSR},  '{8'hAC, B_NOP},  '{8'h80, B_NOP}};
    foreach (tbl[i]) exec_one(tbl[i].b, tbl[i].idx);

    // halt / resume
    exec_one(8'h10, B_HALT);
    for (int i = 0; i < 20; i++) begin
      chk("halt_state", {30'd0, state}, 32'd3);
      chk("halt_strobes", {16'd0, strb()}, 32'h1);
      chk("halt_sm", {31'd0, sm}, 32'd1);
      if (i == 5) begin step = 1'b1; tick(); step = 1'b0; end
      else tick();
    end
    chk("halt_cnt", {28'd0, instr_cnt}, exp_cnt);
    resume = 1'b1; tick(); resume = 1'b0;
    chk("resume_fetch", {30'd0, state}, 32'd0);

    // single-step: resume in WAIT ignored, step leaves WAIT
    step_mode = 1'b1;
    exec_one(8'h96, B_ADD);
    for (int i = 0; i < 10; i++) begin
      chk("wait_state", {30'd0, state}, 32'd2);
      chk("wait_strobes", {16'd0, strb()}, 32'd0);
      chk("wait_sm", {31'd0, sm}, 32'd1);
      if (i == 3) begin resume = 1'b1; tick(); resume = 1'b0; end
      else tick();
    end
    step = 1'b1; tick(); step = 1'b0;
    chk("step_fetch", {30'd0, state}, 32'd0);
    exec_one(8'h60, B_SUB);
    chk("wait2_state", {30'd0, state}, 32'd2);
    step_mode = 1'b0; tick();
    chk("drop_mode_fetch", {30'd0, state}, 32'd0);

    // counter wrap: run 16 nops, expected count rolls through 15 -> 0
    for (int i = 0; i < 16; i++) exec_one(8'h00, B_NOP);

    // reset in the middle of EXEC
    exec_one(8'h96, B_ADD);
    for (int i = 0; i < 30 && state != 2'b00; i++) tick();
    ram_dout = 8'h30; tick();
    chk("pre_rst_exec", {30'd0, state}, 32'd1);
    rst = 1'b1; #1;
    chk("mid_rst_state", {30'd0, state}, 32'd0);
    chk("mid_rst_sm", {31'd0, sm}, 32'd0);
    chk("mid_rst_ir", {24'd0, ir}, 32'd0);
    chk("mid_rst_cnt", {28'd0, instr_cnt}, 32'd0);
    chk("mid_rst_strobes", {16'd0, strb()}, 32'd0);
    tick(); rst = 1'b0;
    exp_cnt = 0;
    exec_one(8'h20, B_IN1);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end
endmodule
